// File: rtl/in_proj_layer_pkg.sv
// Shared types and constants for the input projection stage: data width, PE op modes,
// Q3.12 unity and FSM state encoding.
package in_proj_layer_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned LANES      = 16;

  localparam logic [1:0] MODE_MUL = 2'b01;
  localparam logic [1:0] MODE_MAC = 2'b10;

  localparam logic [DATA_WIDTH-1:0] ONE_FIXED = 16'h1000;

  typedef enum logic [2:0] {
    StIdle,
    StBias,
    StMac,
    StWait,
    StHold
  } state_e;

endpackage

// File: rtl/in_proj_layer.sv
// Input projection y[c] = bias[c] + sum_k W[c][k]*u[k], sequenced over a shared 16-lane PE array.
// Build option: define INPROJ_BIAS_EN to seed each accumulator with bias before the MAC sweep.
module in_proj_layer
  import in_proj_layer_pkg::*;
#(
  parameter int unsigned IN_DIM = 16,
  parameter int unsigned PE_LAT = 1,
  localparam int unsigned DW    = DATA_WIDTH,
  localparam int unsigned KW    = $clog2(IN_DIM),
  localparam int unsigned WCW   = $clog2(PE_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  en,
  input  logic [IN_DIM*DW-1:0]  u_in_vec,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [KW-1:0]         w_idx,
  input  logic [LANES*DW-1:0]   w_col_vec,
  input  logic [LANES*DW-1:0]   bias_vec,
  output logic [LANES*DW-1:0]   y_out_vec,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [1:0]            pe_op_mode_out,
  output logic                  pe_clear_out,
  output logic [LANES*DW-1:0]   pe_in_a_vec,
  output logic [LANES*DW-1:0]   pe_in_b_vec,
  input  logic [LANES*DW-1:0]   pe_result_vec
);

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic                  valid_q, valid_d;
  logic [IN_DIM*DW-1:0]  u_q, u_d;
  logic [LANES*DW-1:0]   y_q, y_d;

`ifndef INPROJ_BIAS_EN
  logic unused_bias;
  assign unused_bias = ^bias_vec;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      wait_q  <= '0;
      valid_q <= 1'b0;
      u_q     <= '0;
      y_q     <= '0;
    end else if (start) begin
      // Abort keeps the last published result on y_out_vec.
      state_q <= StIdle;
      k_q     <= '0;
      wait_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      valid_q <= valid_d;
      u_q     <= u_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    wait_d         = wait_q;
    valid_d        = valid_q;
    u_d            = u_q;
    y_d            = y_q;
    pe_op_mode_out = MODE_MAC;
    pe_clear_out   = 1'b0;
    pe_in_a_vec    = '0;
    pe_in_b_vec    = '0;

    unique case (state_q)
      StIdle: begin
        pe_clear_out = 1'b1;
        if (valid_in && en) begin
          u_d = u_in_vec;
          k_d = '0;
`ifdef INPROJ_BIAS_EN
          state_d = StBias;
`else
          state_d = StMac;
`endif
        end
      end
      StBias: begin
`ifdef INPROJ_BIAS_EN
        if (en) begin
          pe_op_mode_out = MODE_MUL;
          pe_in_a_vec    = bias_vec;
          for (int c = 0; c < LANES; c++) pe_in_b_vec[c*DW +: DW] = ONE_FIXED;
          state_d = StMac;
        end
`else
        state_d = StIdle;
`endif
      end
      StMac: begin
        if (en) begin
`ifndef INPROJ_BIAS_EN
          // Without a bias pass the first product overwrites the cleared accumulator.
          if (k_q == '0) pe_op_mode_out = MODE_MUL;
`endif
          for (int c = 0; c < LANES; c++) pe_in_a_vec[c*DW +: DW] = u_q[int'(k_q)*DW +: DW];
          pe_in_b_vec = w_col_vec;
          if (k_q == KW'(IN_DIM - 1)) begin
            k_d     = '0;
            state_d = StWait;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StWait: begin
        if (en) begin
          if (wait_q == WCW'(PE_LAT - 1)) begin
            y_d     = pe_result_vec;
            valid_d = 1'b1;
            wait_d  = '0;
            state_d = StHold;
          end else begin
            wait_d = wait_q + WCW'(1);
          end
        end
      end
      StHold: begin
        if (ready_out) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ready_in  = (state_q == StIdle) && !start;
  assign w_idx     = k_q;
  assign y_out_vec = y_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_in_proj_layer.sv
// Bench for in_proj_layer: behavioural PE and weight ROM, arithmetic reference model of
// y = bias + W*u checked every cycle valid_out is high, plus directed literal checks.
module tb_in_proj_layer;
  import in_proj_layer_pkg::*;

  localparam int unsigned IN_DIM = 4;
  localparam int unsigned PE_LAT = 1;
  localparam int unsigned DW     = 16;
  localparam int unsigned KW     = $clog2(IN_DIM);
`ifdef INPROJ_BIAS_EN
  localparam int BIAS_EN = 1;
`else
  localparam int BIAS_EN = 0;
`endif
  // Edges after the accept edge until valid_out is seen high.
  localparam int EXP_LAT = IN_DIM + PE_LAT + BIAS_EN;

  logic                 clk, reset, start, en, valid_in, ready_in, valid_out, ready_out;
  logic                 pe_clear_out;
  logic [1:0]           pe_op_mode_out;
  logic [KW-1:0]        w_idx;
  logic [IN_DIM*DW-1:0] u_in_vec;
  logic [16*DW-1:0]     w_col_vec, bias_vec, y_out_vec, pe_in_a_vec, pe_in_b_vec, pe_result_vec;

  logic [15:0] u_arr [IN_DIM];
  logic [15:0] w_arr [16][IN_DIM];
  logic [15:0] b_arr [16];
  logic [15:0] acc   [16];

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_y;

  in_proj_layer #(.IN_DIM(IN_DIM), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .en(en),
    .u_in_vec(u_in_vec), .valid_in(valid_in), .ready_in(ready_in),
    .w_idx(w_idx), .w_col_vec(w_col_vec), .bias_vec(bias_vec),
    .y_out_vec(y_out_vec), .valid_out(valid_out), .ready_out(ready_out),
    .pe_op_mode_out(pe_op_mode_out), .pe_clear_out(pe_clear_out),
    .pe_in_a_vec(pe_in_a_vec), .pe_in_b_vec(pe_in_b_vec), .pe_result_vec(pe_result_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < IN_DIM; k++) u_in_vec[k*DW +: DW] = u_arr[k];
    for (int c = 0; c < 16; c++) begin
      bias_vec[c*DW +: DW]      = b_arr[c];
      w_col_vec[c*DW +: DW]     = w_arr[c][int'(w_idx)];
      pe_result_vec[c*DW +: DW] = acc[c];
    end
  end

  function automatic logic [15:0] sat16(input longint v);
    logic [63:0] t;
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    t = v;
    return t[15:0];
  endfunction

  function automatic logic [15:0] pe_next(input logic [1:0] mode, input logic clr,
                                          input logic [15:0] acc_v, input logic [15:0] a,
                                          input logic [15:0] b);
    longint p;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> 12;
    if (clr) return 16'h0000;
    if (mode == MODE_MUL) return sat16(p);
    return sat16(longint'($signed(acc_v)) + p);
  endfunction

  // Behavioural PE: one-cycle accumulator per lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 16; c++) acc[c] <= 16'h0000;
    end else begin
      for (int c = 0; c < 16; c++)
        acc[c] <= pe_next(pe_op_mode_out, pe_clear_out, acc[c],
                          pe_in_a_vec[c*DW +: DW], pe_in_b_vec[c*DW +: DW]);
    end
  end

  // Reference: y[c] = bias[c] + sum_k u[k]*W[c][k] in Q3.12.
  function automatic logic [255:0] model_y();
    logic [255:0] r;
    longint s;
    r = '0;
    for (int c = 0; c < 16; c++) begin
      s = (BIAS_EN != 0) ? longint'($signed(b_arr[c])) : 0;
      for (int k = 0; k < IN_DIM; k++)
        s += (longint'($signed(u_arr[k])) * longint'($signed(w_arr[c][k]))) >>> 12;
      r[c*16 +: 16] = sat16(s);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle: advance, then compare a held result against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (valid_out) check("y_model", y_out_vec, exp_y);
  endtask

  task automatic load(input logic [15:0] u0, input logic [15:0] u1, input logic [15:0] u2,
                      input logic [15:0] u3, input logic [15:0] w, input logic [15:0] b);
    u_arr[0] = u0; u_arr[1] = u1; u_arr[2] = u2; u_arr[3] = u3;
    for (int c = 0; c < 16; c++) begin
      b_arr[c] = b;
      for (int k = 0; k < IN_DIM; k++) w_arr[c][k] = w;
    end
  endtask

  task automatic send();
    check("ready_before_send", {255'd0, ready_in}, 256'd1);
    valid_in = 1'b1;
    exp_y    = model_y();
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_out && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic release_result();
    ready_out = 1'b1;
    tick();
    ready_out = 1'b0;
    check("valid_after_release", {255'd0, valid_out}, 256'd0);
    check("ready_in_after_release", {255'd0, ready_in}, 256'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [255:0] lit, held;
    reset = 1'b1; start = 1'b0; en = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
    exp_y = '0;
    load(16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0800, 16'h0400);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset_valid_out", {255'd0, valid_out}, 256'd0);
    check("reset_y_out", y_out_vec, 256'd0);
    check("reset_ready_in", {255'd0, ready_in}, 256'd1);
    check("reset_w_idx", {254'd0, w_idx}, 256'd0);
    check("reset_pe_clear", {255'd0, pe_clear_out}, 256'd1);

    // Basic token: 0.25 + 4*(1.0*0.5) = 2.25 with bias, 2.0 without.
    lit = BIAS_EN != 0 ? {16{16'h2400}} : {16{16'h2000}};
    send();
    check("first_issue_mode_mul", {254'd0, pe_op_mode_out}, {254'd0, MODE_MUL});
    wait_valid(n);
    check("latency_basic", n, EXP_LAT);
    check("y_basic_literal", y_out_vec, lit);
    held = y_out_vec;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {255'd0, valid_out}, 256'd1);
      check("hold_y_stable", y_out_vec, held);
      check("hold_ready_in", {255'd0, ready_in}, 256'd0);
    end
    release_result();

    // Stall three cycles while issuing k=2.
    send();
    repeat (BIAS_EN + 2) tick();
    check("stall_w_idx_pre", {254'd0, w_idx}, 256'd2);
    check("stall_a_broadcast", pe_in_a_vec, {16{u_arr[2]}});
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_w_idx", {254'd0, w_idx}, 256'd2);
      check("stall_a_zero", pe_in_a_vec, 256'd0);
      check("stall_clear", {255'd0, pe_clear_out}, 256'd0);
    end
    en = 1'b1;
    wait_valid(n);
    check("latency_stall", n + BIAS_EN + 5, EXP_LAT + 3);
    check("y_stall_literal", y_out_vec, lit);
    held = y_out_vec;
    release_result();

    // Abort at k=1: back to idle, previous result kept on y_out_vec.
    send();
    repeat (BIAS_EN + 1) tick();
    check("abort_w_idx", {254'd0, w_idx}, 256'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("abort_valid_out", {255'd0, valid_out}, 256'd0);
    check("abort_ready_in", {255'd0, ready_in}, 256'd1);
    check("abort_y_kept", y_out_vec, held);
    check("abort_w_idx_zero", {254'd0, w_idx}, 256'd0);

    // Signed accumulate: 1 - 1 + 2 + 0 = 2.0.
    load(16'h1000, 16'hF000, 16'h2000, 16'h0000, 16'h1000, 16'h0000);
    send();
    wait_valid(n);
    check("latency_signed", n, EXP_LAT);
    check("y_signed_literal", y_out_vec, {16{16'h2000}});
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
